sdram_wr_arbiter: RTL and testbench

- Shares one f2h_sdram Avalon-MM burst write port between two streaming write requesters (frame writer, frequency/statistics writer).
- Grants are burst-atomic, round-robin, and honour waitrequest.
- Sits between the HDR pipeline writers and the HPS SDRAM write slave port on the clk100 domain.

---
 rtl/sdram_wr_arbiter_if.sv | 49 ++++
 rtl/sdram_wr_arbiter.sv | 86 ++++++++
 tb/tb_sdram_wr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_arbiter_if.sv
// sdram_wr_arbiter_if: two burst-write requester channels plus the shared f2h_sdram Avalon-MM write port and arbiter status
interface sdram_wr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int BW = 8
);
  logic            r0_req;
  logic [AW-1:0]   r0_address;
  logic [BW-1:0]   r0_burstcount;
  logic            r0_grant;
  logic [DW-1:0]   r0_writedata;
  logic [DW/8-1:0] r0_byteenable;
  logic            r0_valid;
  logic            r0_ready;
  logic            r0_done;
  logic            r1_req;
  logic [AW-1:0]   r1_address;
  logic [BW-1:0]   r1_burstcount;
  logic            r1_grant;
  logic [DW-1:0]   r1_writedata;
  logic [DW/8-1:0] r1_byteenable;
  logic            r1_valid;
  logic            r1_ready;
  logic            r1_done;
  logic [AW-1:0]   avm_address;
  logic [BW-1:0]   avm_burstcount;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_write;
  logic            avm_waitrequest;
  logic            busy;
  logic            owner;
  modport slave (
    input  r0_req, r0_address, r0_burstcount, r0_writedata, r0_byteenable, r0_valid,
    input  r1_req, r1_address, r1_burstcount, r1_writedata, r1_byteenable, r1_valid,
    input  avm_waitrequest,
    output r0_grant, r0_ready, r0_done, r1_grant, r1_ready, r1_done,
    output avm_address, avm_burstcount, avm_writedata, avm_byteenable, avm_write,
    output busy, owner
  );
  modport master (
    output r0_req, r0_address, r0_burstcount, r0_writedata, r0_byteenable, r0_valid,
    output r1_req, r1_address, r1_burstcount, r1_writedata, r1_byteenable, r1_valid,
    output avm_waitrequest,
    input  r0_grant, r0_ready, r0_done, r1_grant, r1_ready, r1_done,
    input  avm_address, avm_burstcount, avm_writedata, avm_byteenable, avm_write,
    input  busy, owner
  );
endinterface

// File: rtl/sdram_wr_arbiter.sv
// sdram_wr_arbiter: burst-atomic round-robin sharing of one f2h_sdram Avalon-MM burst write port between two requesters
module sdram_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int BW = 8
) (
  input logic clk,
  input logic reset,
  sdram_wr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic rr, rr_nx, owner_q, owner_nx, sel, in_burst, wr, acc, last;
  logic [AW-1:0] addr_q, addr_nx;
  logic [BW-1:0] bc_q, bc_nx, cnt, cnt_nx, sel_bc;
  logic [1:0] grant, done;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wbe;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b0;
      owner_q <= 1'b0;
      addr_q <= '0;
      bc_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      rr <= rr_nx;
      owner_q <= owner_nx;
      addr_q <= addr_nx;
      bc_q <= bc_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    rr_nx = rr;
    owner_nx = owner_q;
    addr_nx = addr_q;
    bc_nx = bc_q;
    cnt_nx = cnt;
    grant = '0;
    done = '0;
    in_burst = state == BURST;
    sel = (bus.r0_req & bus.r1_req) ? rr : bus.r1_req;
    sel_bc = sel ? bus.r1_burstcount : bus.r0_burstcount;
    wr = in_burst & (owner_q ? bus.r1_valid : bus.r0_valid) & !reset;
    acc = wr & !bus.avm_waitrequest;
    last = acc & (cnt + BW'(1) == bc_q);
    if (!in_burst & (bus.r0_req | bus.r1_req)) begin
      grant[sel] = 1'b1;
      owner_nx = sel;
      addr_nx = sel ? bus.r1_address : bus.r0_address;
      bc_nx = sel_bc;
      cnt_nx = '0;
      if (sel_bc == '0) begin
        done[sel] = 1'b1;
        rr_nx = !sel;
      end else begin
        state_nx = BURST;
      end
    end
    if (acc) cnt_nx = cnt + BW'(1);
    if (last) begin
      done[owner_q] = 1'b1;
      state_nx = IDLE;
      rr_nx = !owner_q;
    end
  end
  assign wdata = owner_q ? bus.r1_writedata : bus.r0_writedata;
  assign wbe = owner_q ? bus.r1_byteenable : bus.r0_byteenable;
  assign bus.r0_grant = grant[0] & !reset;
  assign bus.r1_grant = grant[1] & !reset;
  assign bus.r0_done = done[0] & !reset;
  assign bus.r1_done = done[1] & !reset;
  assign bus.r0_ready = in_burst & !owner_q & !bus.avm_waitrequest & !reset;
  assign bus.r1_ready = in_burst & owner_q & !bus.avm_waitrequest & !reset;
  assign bus.avm_write = wr;
  assign bus.avm_writedata = wdata;
  assign bus.avm_byteenable = wbe;
  assign bus.avm_address = addr_q;
  assign bus.avm_burstcount = bc_q;
  assign bus.busy = in_burst;
  assign bus.owner = owner_q;
endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// tb_sdram_wr_arbiter: table-driven bursts plus arbitration and reset sequences, beats checked against a scoreboard queue
module tb_sdram_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sdram_wr_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();
  sdram_wr_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [AW-1:0]   a;
    logic [BW-1:0]   bc;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] be;
  } beat_t;
  typedef struct {
    int            rid;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [15:0]   vmask;
    logic [15:0]   wmask;
    int            exp_cycles;
  } vec_t;
  beat_t sb[$];
  vec_t vt[6];
  int tests = 0;
  int fails = 0;
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] mkdata(int rid, int beat, logic [AW-1:0] a);
    return 64'hA5A5_0000_0000_0000 ^ (64'(rid) << 48) ^ (64'(a) << 16) ^ 64'(beat);
  endfunction
  function automatic logic [DW/8-1:0] mkbe(int rid, int beat);
    return 8'(beat * 37 + rid * 11 + 1);
  endfunction
  function automatic logic gr(int rid);
    return rid == 0 ? bus.r0_grant : bus.r1_grant;
  endfunction
  function automatic logic dn(int rid);
    return rid == 0 ? bus.r0_done : bus.r1_done;
  endfunction
  function automatic logic rdy(int rid);
    return rid == 0 ? bus.r0_ready : bus.r1_ready;
  endfunction
  task automatic set_req(int rid, logic r, logic [AW-1:0] a, logic [BW-1:0] bc);
    if (rid == 0) begin
      bus.r0_req = r;
      bus.r0_address = a;
      bus.r0_burstcount = bc;
    end else begin
      bus.r1_req = r;
      bus.r1_address = a;
      bus.r1_burstcount = bc;
    end
  endtask
  task automatic set_beat(int rid, logic v, logic [AW-1:0] a, int beat);
    if (rid == 0) begin
      bus.r0_valid = v;
      bus.r0_writedata = mkdata(0, beat, a);
      bus.r0_byteenable = mkbe(0, beat);
    end else begin
      bus.r1_valid = v;
      bus.r1_writedata = mkdata(1, beat, a);
      bus.r1_byteenable = mkbe(1, beat);
    end
  endtask
  task automatic push_burst(int rid, logic [AW-1:0] a, logic [BW-1:0] bc);
    beat_t e;
    for (int b = 0; b < int'(bc); b++) begin
      e.a = a;
      e.bc = bc;
      e.d = mkdata(rid, b, a);
      e.be = mkbe(rid, b);
      sb.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    beat_t e;
    if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_addr", bus.avm_address, e.a);
        chk("beat_bc", bus.avm_burstcount, e.bc);
        chk("beat_data", bus.avm_writedata, e.d);
        chk("beat_be", bus.avm_byteenable, e.be);
      end
    end
  end
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic run_burst(vec_t v);
    int k;
    int beat;
    logic got;
    logic vb;
    logic wb;
    @(posedge clk);
    #1 set_req(v.rid, 1'b1, v.addr, v.bc);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gr(v.rid)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("grant_seen", got, 1);
    if (!got) begin
      set_req(v.rid, 1'b0, v.addr, v.bc);
      return;
    end
    chk("grant_other", gr(1 - v.rid), 0);
    chk("write_at_grant", bus.avm_write, 0);
    if (v.bc == 0) begin
      chk("zero_done", dn(v.rid), 1);
      @(posedge clk);
      #1 set_req(v.rid, 1'b0, v.addr, v.bc);
      @(negedge clk);
      chk("zero_busy", bus.busy, 0);
      chk("zero_write", bus.avm_write, 0);
      chk("zero_owner", bus.owner, v.rid);
      return;
    end
    chk("early_done", dn(v.rid), 0);
    push_burst(v.rid, v.addr, v.bc);
    @(posedge clk);
    #1 set_req(v.rid, 1'b0, v.addr, v.bc);
    beat = 0;
    for (k = 1; k <= 30; k++) begin
      vb = (k <= 16) ? v.vmask[k-1] : 1'b1;
      wb = (k <= 16) ? v.wmask[k-1] : 1'b0;
      set_beat(v.rid, vb, v.addr, beat);
      bus.avm_waitrequest = wb;
      @(negedge clk);
      chk("busy", bus.busy, 1);
      chk("owner", bus.owner, v.rid);
      chk("addr_hold", bus.avm_address, v.addr);
      chk("bc_hold", bus.avm_burstcount, v.bc);
      chk("write_follows_valid", bus.avm_write, vb);
      chk("ready", rdy(v.rid), !wb);
      chk("ready_other", rdy(1 - v.rid), 0);
      if (vb) chk("wdata_stable", bus.avm_writedata, mkdata(v.rid, beat, v.addr));
      if (vb && !wb) beat++;
      chk("done", dn(v.rid), (beat == int'(v.bc)) && vb && !wb);
      if (beat == int'(v.bc)) break;
      @(posedge clk);
      #1;
    end
    chk("done_cycle", k, v.exp_cycles);
    @(posedge clk);
    #1 set_beat(v.rid, 1'b0, v.addr, 0);
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int ng;
    int nd;
    int last_done;
    int b0;
    int b1;
    int order[3];
    int b;
    logic got;
    vt[0] = '{0, 32'h100, 8'd4, 16'hFFFF, 16'h0000, 4};
    vt[1] = '{0, 32'h140, 8'd4, 16'hFFFF, 16'h000E, 7};
    vt[2] = '{1, 32'h180, 8'd3, 16'h0019, 16'h0000, 5};
    vt[3] = '{1, 32'h1C0, 8'd0, 16'hFFFF, 16'h0000, 0};
    vt[4] = '{1, 32'h1E0, 8'd1, 16'hFFFE, 16'h0000, 2};
    vt[5] = '{0, 32'h1F0, 8'd2, 16'hFFFF, 16'h0001, 3};
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    set_beat(0, 1'b0, '0, 0);
    set_beat(1, 1'b0, '0, 0);
    bus.avm_waitrequest = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_addr", bus.avm_address, 0);
    chk("rst_bc", bus.avm_burstcount, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_grants", {bus.r0_grant, bus.r1_grant}, 0);
    chk("rst_readies", {bus.r0_ready, bus.r1_ready}, 0);
    chk("rst_dones", {bus.r0_done, bus.r1_done}, 0);
    foreach (vt[i]) run_burst(vt[i]);
    do_reset();
    set_req(0, 1'b1, 32'h400, 8'd2);
    set_req(1, 1'b1, 32'h500, 8'd2);
    set_beat(0, 1'b1, 32'h400, 0);
    set_beat(1, 1'b1, 32'h500, 0);
    ng = 0;
    nd = 0;
    last_done = -100;
    b0 = 0;
    b1 = 0;
    for (int cyc = 0; cyc < 60 && nd < 3; cyc++) begin
      @(negedge clk);
      if (bus.r0_grant || bus.r1_grant) begin
        chk("alt_single_grant", bus.r0_grant & bus.r1_grant, 0);
        chk("alt_grant_in_idle", bus.busy, 0);
        if (ng < 3) order[ng] = int'(bus.r1_grant);
        if (ng > 0) chk("alt_gap", cyc - last_done, 1);
        ng++;
        if (bus.r1_grant) begin
          push_burst(1, 32'h500, 8'd2);
          b1 = 0;
        end else begin
          push_burst(0, 32'h400, 8'd2);
          b0 = 0;
        end
      end
      if (bus.r0_ready && bus.r0_valid) b0++;
      if (bus.r1_ready && bus.r1_valid) b1++;
      if (bus.r0_done || bus.r1_done) begin
        nd++;
        last_done = cyc;
      end
      @(posedge clk);
      #1;
      if (ng >= 3) begin
        set_req(0, 1'b0, 32'h400, 8'd2);
        set_req(1, 1'b0, 32'h500, 8'd2);
      end
      set_beat(0, 1'b1, 32'h400, b0);
      set_beat(1, 1'b1, 32'h500, b1);
    end
    chk("alt_grants", ng, 3);
    chk("alt_dones", nd, 3);
    chk("alt_order0", order[0], 0);
    chk("alt_order1", order[1], 1);
    chk("alt_order2", order[2], 0);
    set_beat(0, 1'b0, 32'h400, 0);
    set_beat(1, 1'b0, 32'h500, 0);
    @(posedge clk);
    #1 set_req(0, 1'b1, 32'h600, 8'd8);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      got = bus.r0_grant;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_grant", got, 1);
    push_burst(0, 32'h600, 8'd8);
    set_req(0, 1'b0, 32'h600, 8'd8);
    b = 0;
    set_beat(0, 1'b1, 32'h600, b);
    for (int i = 0; i < 10 && b < 2; i++) begin
      @(negedge clk);
      if (bus.r0_ready && bus.r0_valid) b++;
      @(posedge clk);
      #1 set_beat(0, 1'b1, 32'h600, b);
    end
    chk("rst_mid_beats", b, 2);
    reset = 1'b1;
    sb.delete();
    set_beat(0, 1'b0, 32'h600, b);
    @(negedge clk);
    chk("rst_mid_no_done", bus.r0_done, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_owner", bus.owner, 0);
    chk("rst_mid_addr", bus.avm_address, 0);
    chk("rst_mid_bc", bus.avm_burstcount, 0);
    chk("rst_mid_write", bus.avm_write, 0);
    chk("rst_mid_ready", bus.r0_ready, 0);
    chk("rst_mid_done2", bus.r0_done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(1, 1'b1, 32'h700, 8'd1);
    @(negedge clk);
    chk("post_rst_grant", bus.r1_grant, 1);
    chk("post_rst_no_done", bus.r0_done, 0);
    push_burst(1, 32'h700, 8'd1);
    @(posedge clk);
    #1 set_req(1, 1'b0, 32'h700, 8'd1);
    set_beat(1, 1'b1, 32'h700, 0);
    @(negedge clk);
    chk("post_rst_owner", bus.owner, 1);
    chk("post_rst_done", bus.r1_done, 1);
    @(posedge clk);
    #1 set_beat(1, 1'b0, 32'h700, 0);
    @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
